// File: rtl/bcd_counter_chain_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared BCD digit type, width constant and clamp helper for the cascaded
// BCD counter chain (bcd_counter_chain / bcd_digit).
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Saturate a loaded nibble to the digit's terminal value. Non-BCD
    // nibbles (A..F) are always above any legal limit, so they clamp too.
    function automatic bcd_t bcd_clamp(input bcd_t val, input bcd_t lim);
        bcd_t res;
        if (val > lim) begin
            res = lim;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_counter_chain_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One BCD digit of the counter chain with a programmable terminal value.
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   step       in   advance this digit one count this cycle
//   up         in   direction, 1 = increment, 0 = decrement
//   clear      in   synchronous clear to zero
//   load       in   parallel load strobe
//   load_digit in   value to load (clamped to limit)
//   limit      in   terminal value of this digit (1..9)
//   q          out  current digit value
//   at_term    out  digit sits at its terminal value for the current direction
// ---------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic [BCD_W-1:0] limit,
    output logic [BCD_W-1:0] q,
    output logic             at_term
);

    bcd_t q_q;
    bcd_t q_d;

    // Next digit value: clear > load > step, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = 4'd0;
        end else if (load) begin
            q_d = bcd_clamp(load_digit, limit);
        end else if (step) begin
            if (up) begin
                if (q_q == limit) begin
                    q_d = 4'd0;
                end else begin
                    q_d = q_q + 4'd1;
                end
            end else begin
                if (q_q == 4'd0) begin
                    q_d = limit;
                end else begin
                    q_d = q_q - 4'd1;
                end
            end
        end else begin
            q_d = q_q;
        end
    end

    // Digit state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    // Terminal detect: the value from which the next step rolls over.
    always_comb begin
        at_term = 1'b0;
        if (up) begin
            at_term = (q_q == limit);
        end else begin
            at_term = (q_q == 4'd0);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bcd_counter_chain.sv
// ---------------------------------------------------------------------------
// bcd_counter_chain
// Multi-digit cascaded BCD up/down counter with per-digit terminal values,
// parallel load, synchronous clear, terminal-count flag and wrap pulse.
// Optional snapshot register enabled by the macro BCD_LAP_EN.
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   synchronous active-low reset
//   enable    in   count-step qualifier
//   up        in   direction, 1 = increment, 0 = decrement
//   clear     in   synchronous clear to zero
//   load      in   parallel load strobe
//   load_val  in   BCD load value, digit 0 in LSBs
//   Q         out  current count, BCD
//   done      out  combinational terminal-count flag
//   wrap      out  registered one-cycle pulse after the chain wraps
//   lap       in   snapshot strobe            (BCD_LAP_EN only)
//   lap_Q     out  snapshot of Q before edge  (BCD_LAP_EN only)
// ---------------------------------------------------------------------------
module bcd_counter_chain
    import bcd_pkg::*;
#(
    parameter int                   DIGITS = 4,
    parameter logic [4*DIGITS-1:0]  LIMITS = 16'h5959
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Q,
`ifdef BCD_LAP_EN
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   lap_Q,
`endif
    output logic                  done,
    output logic                  wrap
);

    logic [DIGITS-1:0] at_term_s;
    // carry_s[d] is the step for digit d: enable AND every lower digit at term.
    logic [DIGITS:0]   carry_s;
    logic              wrap_q;
    logic              wrap_d;

    assign carry_s[0] = enable;

    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .reset_n    (reset_n),
                .step       (carry_s[d]),
                .up         (up),
                .clear      (clear),
                .load       (load),
                .load_digit (load_val[BCD_W*d +: BCD_W]),
                .limit      (LIMITS[BCD_W*d +: BCD_W]),
                .q          (Q[BCD_W*d +: BCD_W]),
                .at_term    (at_term_s[d])
            );
            assign carry_s[d+1] = carry_s[d] & at_term_s[d];
        end
    endgenerate

    // Whole chain at its terminal value for the current direction.
    assign done = &at_term_s;

    // Wrap pulse: a step taken while done rolls the whole chain over.
    always_comb begin
        wrap_d = 1'b0;
        if (clear || load) begin
            wrap_d = 1'b0;
        end else if (enable && done) begin
            wrap_d = 1'b1;
        end else begin
            wrap_d = 1'b0;
        end
    end

    // Wrap pulse register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

`ifdef BCD_LAP_EN
    logic [4*DIGITS-1:0] lap_q;

    // Snapshot register: captures Q as it stands before this edge's update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lap_q <= '0;
        end else if (lap) begin
            lap_q <= Q;
        end else begin
            lap_q <= lap_q;
        end
    end

    assign lap_Q = lap_q;
`endif

endmodule

// File: tb/tb_bcd_counter_chain.sv
module tb_bcd_counter_chain;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        up;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] Q;
    logic        done;
    logic        wrap;
`ifdef BCD_LAP_EN
    logic        lap;
    logic [15:0] lap_Q;
`endif

    int errors = 0;
    int checks = 0;

    bcd_counter_chain #(
        .DIGITS (4),
        .LIMITS (16'h5959)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .up       (up),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .Q        (Q),
`ifdef BCD_LAP_EN
        .lap      (lap),
        .lap_Q    (lap_Q),
`endif
        .done     (done),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_q;
        int n;

        reset_n  = 1'b0;
        enable   = 1'b0;
        up       = 1'b1;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 16'h0000;
`ifdef BCD_LAP_EN
        lap      = 1'b0;
`endif

        // Reset for two cycles
        tick();
        tick();
        check("reset_Q", {16'h0, Q}, 32'h0000);
        check("reset_wrap", {31'h0, wrap}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);

        // Count up 60 steps: 0000 -> 0059 -> 0100, done never set
        reset_n = 1'b1;
        enable  = 1'b1;
        up      = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            n = i;
            if (n < 60) exp_q = 16'((n / 10) * 16 + (n % 10));
            else        exp_q = 16'h0100;
            check("count_Q", {16'h0, Q}, {16'h0, exp_q});
            check("count_done", {31'h0, done}, 32'h0);
        end

        // Carry through middle digits: 0959 -> 1000
        enable = 1'b0; load = 1'b1; load_val = 16'h0959;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        check("carry_Q", {16'h0, Q}, 32'h1000);

        // Full wrap up from 5958
        enable = 1'b0; load = 1'b1; load_val = 16'h5958;
        tick();
        check("load5958_Q", {16'h0, Q}, 32'h5958);
        check("load5958_done", {31'h0, done}, 32'h0);
        load = 1'b0; enable = 1'b1;
        tick();
        check("up_term_Q", {16'h0, Q}, 32'h5959);
        check("up_term_done", {31'h0, done}, 32'h1);
        check("up_term_wrap", {31'h0, wrap}, 32'h0);
        tick();
        check("up_wrap_Q", {16'h0, Q}, 32'h0000);
        check("up_wrap_pulse", {31'h0, wrap}, 32'h1);
        check("up_wrap_done", {31'h0, done}, 32'h0);
        enable = 1'b0;
        tick();
        check("up_wrap_once", {31'h0, wrap}, 32'h0);
        check("hold_Q", {16'h0, Q}, 32'h0000);

        // Down wrap from 0000
        up = 1'b0;
        #1;
        check("down_done_comb", {31'h0, done}, 32'h1);
        enable = 1'b1;
        tick();
        check("down_wrap_Q", {16'h0, Q}, 32'h5959);
        check("down_wrap_pulse", {31'h0, wrap}, 32'h1);
        check("down_wrap_done", {31'h0, done}, 32'h0);
        tick();
        check("down_next_Q", {16'h0, Q}, 32'h5958);
        check("down_next_wrap", {31'h0, wrap}, 32'h0);

        // Borrow through middle digits: 0100 -> 0059
        enable = 1'b0; load = 1'b1; load_val = 16'h0100;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        check("borrow_Q", {16'h0, Q}, 32'h0059);

        // Load clamp with load beating enable: 7A3C -> 5939
        up = 1'b1; load = 1'b1; enable = 1'b1; load_val = 16'h7A3C;
        tick();
        check("clamp_Q", {16'h0, Q}, 32'h5939);
        check("clamp_wrap", {31'h0, wrap}, 32'h0);

        // Clear beats load
        clear = 1'b1; load = 1'b1; load_val = 16'h1234;
        tick();
        check("clear_Q", {16'h0, Q}, 32'h0000);
        clear = 1'b0; load = 1'b0;

        // Synchronous reset mid-count at 0123
        enable = 1'b0; load = 1'b1; load_val = 16'h0123;
        tick();
        load = 1'b0; enable = 1'b1; reset_n = 1'b0;
        #1;
        check("sync_rst_pre_Q", {16'h0, Q}, 32'h0123);
        tick();
        check("sync_rst_Q", {16'h0, Q}, 32'h0000);
        check("sync_rst_wrap", {31'h0, wrap}, 32'h0);
        reset_n = 1'b1;
        tick();
        check("post_rst_Q", {16'h0, Q}, 32'h0001);

`ifdef BCD_LAP_EN
        // Lap snapshot at 0042 while counting
        enable = 1'b0; load = 1'b1; load_val = 16'h0042;
        tick();
        load = 1'b0; enable = 1'b1; lap = 1'b1;
        tick();
        check("lap_capture", {16'h0, lap_Q}, 32'h0042);
        check("lap_Q_count", {16'h0, Q}, 32'h0043);
        lap = 1'b0;
        tick();
        check("lap_hold", {16'h0, lap_Q}, 32'h0042);
        check("lap_Q_count2", {16'h0, Q}, 32'h0044);
        // Lap with simultaneous clear captures pre-clear value
        lap = 1'b1; clear = 1'b1;
        tick();
        check("lap_clear_capture", {16'h0, lap_Q}, 32'h0044);
        check("lap_clear_Q", {16'h0, Q}, 32'h0000);
        lap = 1'b0; clear = 1'b0;
`endif

        enable = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
- Multi-digit cascaded BCD counter with a per-digit programmable terminal value.
- Supports up/down counting, parallel load, synchronous clear, a terminal-count flag and a registered wrap pulse.
- Generalises the single-digit stopwatch counter into one block that can drive a complete stopwatch display chain, e.g. mm:ss = 59:59.
- Sits between the tick/prescaler enable and the seven-segment display driver.

Parameters:
- DIGITS, 4, number of cascaded BCD digits; legal range 1..8.
- LIMITS, 16'h5959, packed per-digit terminal values, 4 bits per digit, digit 0 in bits [3:0]. Each nibble must be 1..9. Width is 4*DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  count-step qualifier; one step per cycle when high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clear  in  1  synchronous clear to all zeros.
- load  in  1  parallel load strobe.
- load_val  in  4*DIGITS  value to load, BCD, digit 0 in LSBs.
- Q  out  4*DIGITS  current count, BCD.
- done  out  1  combinational terminal-count flag.
- wrap  out  1  registered one-cycle pulse when the chain wraps.
- lap_Q  out  4*DIGITS  captured snapshot; present only with BCD_LAP_EN.
- lap  in  1  snapshot strobe; present only with BCD_LAP_EN.

Behaviour:
- Reset (reset_n=0 at a clk edge): Q=0, wrap=0, lap_Q=0. Reset overrides every other input.
- Priority per cycle: reset_n > clear > load > enable. No step occurs in a cycle where clear or load is active.
- clear=1: Q<=0 and wrap<=0.
- load=1:
  - Each digit d gets load_val nibble d, clamped to LIMITS nibble d if it exceeds that limit.
  - Non-BCD nibbles (A..F) clamp the same way.
  - wrap<=0.
- enable=1, up=1:
  - Digit 0 increments.
  - Digit d steps only if every lower digit j<d equals LIMITS[j].
  - A stepping digit equal to its limit goes to 0; otherwise it goes to +1.
- enable=1, up=0:
  - Digit 0 decrements.
  - Digit d steps only if every lower digit equals 0.
  - A stepping digit equal to 0 goes to its limit; otherwise it goes to -1.
- done:
  - up=1: done = all digits at their limits.
  - up=0: done = all digits at 0.
  - Purely combinational from Q and up, no latency.
- wrap:
  - wrap<=1 for exactly one cycle, the cycle after a step taken while done=1.
  - For this step, up: Q goes all-limits->0; down: Q goes 0->all-limits.
  - Otherwise wrap<=0.
- enable=0 with no clear or load: Q holds and wrap<=0.
- Changing direction mid-count is legal. The step uses the up value sampled at that edge.
- Latency: Q updates on the clock edge where enable, load or clear is sampled; no pipeline.
- DIGITS=1 degenerates to a single-digit counter with limit LIMITS[3:0].

Optional Feature:
- Macro: BCD_LAP_EN.
- Defined:
  - Adds the lap input and the lap_Q output.
  - On lap=1, lap_Q<=Q as it stands before this edge's update.
  - lap_Q holds otherwise and resets to 0 with reset_n.
  - lap is independent of enable, load and clear. A simultaneous clear still captures the pre-clear Q.
- Not defined: lap and lap_Q ports are absent, and no snapshot register is synthesised.

Decomposition:
- Package bcd_pkg:
  - BCD_W=4 constant.
  - bcd_t 4-bit digit typedef.
  - BCD_MAX=4'd9.
  - Function bcd_clamp(val, lim).
- Sub-module bcd_digit, instantiated DIGITS times in a generate loop:
  - Ports: clk, reset_n, step, up, clear, load, load_digit, limit, q, at_term.
  - at_term = (q==limit) when up=1, (q==0) when up=0.
  - The chain step for digit d is enable AND the at_term of all lower digits.
  - The top level derives done and wrap from the at_term values.

Test Plan:
- Reset then count (DIGITS=4, LIMITS=16'h5959): reset_n=0 for 2 cycles, then enable=1, up=1 for 60 cycles -> Q goes 0000->0059->0100; done=0 throughout.
- Full wrap up: load 16'h5958, then enable 2 cycles up -> Q=5959 with done=1, then Q=0000 with wrap=1 for exactly one cycle.
- Down wrap: Q=0000, up=0 -> done=1; one enable -> Q=5959, wrap pulse. Next enable -> Q=5958 and wrap=0.
- Load clamp and priority:
  - load_val=16'h7A3C with load=1 and enable=1 -> Q=5939; no step that cycle.
  - Then clear=1 and load=1 together -> Q=0000.
- Synchronous reset mid-count: at Q=0123 with enable=1, assert reset_n=0 for 1 cycle -> next Q=0000, wrap=0. Q does not change before the clock edge.
- BCD_LAP_EN: at Q=0042 pulse lap with enable=1 -> lap_Q=0042 and Q=0043; lap_Q holds while counting continues.
